// File: rtl/prefix_add_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake and tag sideband.
// Zero/overflow flag outputs exist only when PREFIX_ADD_FLAGS_EN is defined.
module prefix_add_pipe #(
  parameter int WIDTH         = 64,
  parameter int LVL_PER_STAGE = 1,
  parameter int TAG_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag,
`ifdef PREFIX_ADD_FLAGS_EN
  output logic             out_zero,
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int NSTG   = (LEVELS + LVL_PER_STAGE - 1) / LVL_PER_STAGE;

  // Kogge-Stone levels lo..hi-1; returns {group generate, group propagate}.
  function automatic logic [2*WIDTH-1:0] ks_levels(input logic [WIDTH-1:0] g_in,
                                                   input logic [WIDTH-1:0] pg_in,
                                                   input int lo, input int hi);
    logic [WIDTH-1:0] g, pg, low;
    int span;
    g  = g_in;
    pg = pg_in;
    for (int k = 0; k < LEVELS; k++) begin
      if (k >= lo && k < hi) begin
        span = 1 << k;
        low  = (WIDTH'(1) << span) - WIDTH'(1);
        g    = g | (pg & (g << span));
        pg   = pg & ((pg << span) | low);
      end
    end
    return {g, pg};
  endfunction

  function automatic int lvl_hi(input int s);
    return (s * LVL_PER_STAGE < LEVELS) ? s * LVL_PER_STAGE : LEVELS;
  endfunction

  logic [WIDTH-1:0] r_g   [NSTG];
  logic [WIDTH-1:0] r_pg  [NSTG];
  logic [WIDTH-1:0] r_p   [NSTG];
  logic             r_cin [NSTG];
  logic [TAG_W-1:0] r_tag [NSTG];
  logic             r_vld [NSTG];
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout;
  logic [TAG_W-1:0] r_out_tag;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic [WIDTH-1:0] w_g_nxt  [NSTG];
  logic [WIDTH-1:0] w_pg_nxt [NSTG];
  logic [WIDTH-1:0] w_fin_g;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_advance;

  assign w_b_eff   = in_sub ? ~in_b : in_b;
  assign w_cin_eff = in_sub | in_cin;
  assign w_advance = !(r_out_valid && !out_ready);
  assign in_ready  = w_advance;

  // Carry-in is folded into bit 0 generate so the prefix tree yields carries directly.
  always_comb begin
    w_g_nxt[0]  = (in_a & w_b_eff) |
                  {{(WIDTH-1){1'b0}}, (in_a[0] ^ w_b_eff[0]) & w_cin_eff};
    w_pg_nxt[0] = in_a ^ w_b_eff;
    for (int s = 1; s < NSTG; s++) begin
      {w_g_nxt[s], w_pg_nxt[s]} = ks_levels(r_g[s-1], r_pg[s-1],
                                            (s-1) * LVL_PER_STAGE, lvl_hi(s));
    end
  end

  always_comb begin
    w_fin_g = WIDTH'(ks_levels(r_g[NSTG-1], r_pg[NSTG-1],
                               (NSTG-1) * LVL_PER_STAGE, LEVELS) >> WIDTH);
    w_sum   = r_p[NSTG-1] ^ {w_fin_g[WIDTH-2:0], r_cin[NSTG-1]};
    w_cout  = w_fin_g[WIDTH-1];
  end

`ifdef PREFIX_ADD_FLAGS_EN
  logic r_amsb [NSTG];
  logic r_bmsb [NSTG];
  logic r_out_zero;
  logic r_out_ovf;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_zero <= 1'b0;
      r_out_ovf  <= 1'b0;
    end else if (w_advance) begin
      r_amsb[0]  <= in_a[WIDTH-1];
      r_bmsb[0]  <= w_b_eff[WIDTH-1];
      for (int s = 1; s < NSTG; s++) begin
        r_amsb[s] <= r_amsb[s-1];
        r_bmsb[s] <= r_bmsb[s-1];
      end
      r_out_zero <= (w_sum == '0);
      r_out_ovf  <= (r_amsb[NSTG-1] == r_bmsb[NSTG-1]) &&
                    (w_sum[WIDTH-1] != r_amsb[NSTG-1]);
    end
  end

  assign out_zero = r_out_zero;
  assign out_ovf  = r_out_ovf;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < NSTG; s++) r_vld[s] <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_tag   <= '0;
    end else if (w_advance) begin
      r_vld[0] <= in_valid;
      r_cin[0] <= w_cin_eff;
      r_tag[0] <= in_tag;
      r_p[0]   <= w_pg_nxt[0];
      for (int s = 0; s < NSTG; s++) begin
        r_g[s]  <= w_g_nxt[s];
        r_pg[s] <= w_pg_nxt[s];
      end
      for (int s = 1; s < NSTG; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_cin[s] <= r_cin[s-1];
        r_tag[s] <= r_tag[s-1];
        r_p[s]   <= r_p[s-1];
      end
      r_out_valid <= r_vld[NSTG-1];
      r_out_sum   <= w_sum;
      r_out_cout  <= w_cout;
      r_out_tag   <= r_tag[NSTG-1];
    end
  end

  always_comb begin
    busy = r_out_valid;
    for (int s = 0; s < NSTG; s++) busy = busy | r_vld[s];
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_tag   = r_out_tag;

endmodule
